// File: rtl/spi_pkg.sv
// Shared SPI types and helpers: slave FSM states, word width, mode bundle
// and the bit-order aware shift helpers used by both master and slave.
package spi_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_slv_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic msb_lsb;
  } spi_mode_t;

  // Bit that goes on the wire first for the selected order.
  function automatic logic head_bit(input logic [SPI_W-1:0] w, input logic msb_first);
    return msb_first ? w[SPI_W-1] : w[0];
  endfunction

  // Drop the bit just transmitted; vacated position fills with one (idle line level).
  function automatic logic [SPI_W-1:0] shift_out(input logic [SPI_W-1:0] w, input logic msb_first);
    return msb_first ? {w[SPI_W-2:0], 1'b1} : {1'b1, w[SPI_W-1:1]};
  endfunction

  // Append one received bit in the selected order.
  function automatic logic [SPI_W-1:0] shift_in(input logic [SPI_W-1:0] w, input logic b,
                                                input logic msb_first);
    return msb_first ? {w[SPI_W-2:0], b} : {b, w[SPI_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus history flop for an asynchronous pin.
// Edges are reported from synchronizer stage 2 against the history flop.
// The flops carry no reset: clearing them would fabricate a pin edge
// (e.g. a chip-select fall while the pin is already low).
module spi_sync_edge (
  input  logic clk,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;

  // Next values of the synchronizer chain.
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
    hist_q  <= hist_d;
  end

  assign level = sync2_q;
  assign rise  = sync2_q & ~hist_q;
  assign fall  = ~sync2_q & hist_q;

endmodule

// File: rtl/spi_slave_sv.sv
// SPI slave: oversamples sck/cs/sdi, receives 8-bit words into rx_data and
// returns words from a one-entry shadow register on sdo. All four CPOL/CPHA
// modes and both bit orders; mode is latched at the chip-select fall.
module spi_slave_sv
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tr_en,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             msb_lsb,
  input  logic [SPI_W-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [SPI_W-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             busy,
  input  logic             sck,
  input  logic             cs,
  input  logic             sdi,
  output logic             sdo,
  output logic             sdo_oe
);

  spi_slv_state_t   state_q, state_d;
  spi_mode_t        mode_q, mode_d;
  logic [SPI_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_W-1:0] shadow_q, shadow_d;
  logic [SPI_W-1:0] rx_data_q, rx_data_d;
  logic [2:0]       bit_c_q, bit_c_d;
  logic             shadow_full_q, shadow_full_d;
  logic             word_bnd_q, word_bnd_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             sdo_q, sdo_d;
  logic             sdo_oe_q, sdo_oe_d;
  logic             sdi_s1_q, sdi_s1_d;
  logic             sdi_s2_q, sdi_s2_d;

  logic             sck_level_s, sck_rise_s, sck_fall_s;
  logic             cs_level_s, cs_rise_s, cs_fall_s;
  logic             sck_edge_s, lead_s, trail_s, sample_s, shout_s;
  logic             wr_s, reload_s;
  logic [SPI_W-1:0] reload_word_s, rx_next_s;

  spi_sync_edge u_sck_sync (
    .clk   (clk),
    .pin   (sck),
    .level (sck_level_s),
    .rise  (sck_rise_s),
    .fall  (sck_fall_s)
  );

  spi_sync_edge u_cs_sync (
    .clk   (clk),
    .pin   (cs),
    .level (cs_level_s),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  // sdi follows the same two-stage delay so stage 2 lines up with the sck edge.
  always_comb begin
    sdi_s1_d = sdi;
    sdi_s2_d = sdi_s1_q;
  end

  // sdi synchronizer registers (no reset, same reasoning as spi_sync_edge).
  always_ff @(posedge clk) begin
    sdi_s1_q <= sdi_s1_d;
    sdi_s2_q <= sdi_s2_d;
  end

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sck_edge_s    = sck_rise_s | sck_fall_s;
  assign lead_s        = sck_edge_s & (sck_level_s ^ mode_q.cpol);
  assign trail_s       = sck_edge_s & ~(sck_level_s ^ mode_q.cpol);
  assign sample_s      = mode_q.cpha ? trail_s : lead_s;
  assign shout_s       = mode_q.cpha ? lead_s : trail_s;
  assign wr_s          = tx_valid & ~shadow_full_q;
  assign reload_word_s = shadow_full_q ? shadow_q : 8'hFF;
  assign rx_next_s     = shift_in(rx_sh_q, sdi_s2_q, mode_q.msb_lsb);

  // FSM next state, shift datapath, shadow bookkeeping and output pulses.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    tx_sh_d       = tx_sh_q;
    rx_sh_d       = rx_sh_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    rx_data_d     = rx_data_q;
    bit_c_d       = bit_c_q;
    word_bnd_d    = word_bnd_q;
    busy_d        = busy_q;
    sdo_d         = sdo_q;
    sdo_oe_d      = sdo_oe_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    reload_s      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        sdo_d      = 1'b1;
        sdo_oe_d   = 1'b0;
        bit_c_d    = 3'd0;
        word_bnd_d = 1'b0;
        if (cs_fall_s) begin
          state_d        = LOAD;
          mode_d.cpol    = cpol;
          mode_d.cpha    = cpha;
          mode_d.msb_lsb = msb_lsb;
          busy_d         = 1'b1;
          sdo_oe_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        reload_s      = 1'b1;
        tx_underrun_d = ~shadow_full_q;
        bit_c_d       = 3'd0;
        word_bnd_d    = 1'b0;
        if (mode_q.cpha) begin
          // First bit goes out on the first leading edge.
          tx_sh_d = reload_word_s;
        end else begin
          sdo_d   = head_bit(reload_word_s, mode_q.msb_lsb);
          tx_sh_d = shift_out(reload_word_s, mode_q.msb_lsb);
        end
        if (cs_rise_s) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          sdo_oe_d = 1'b0;
          sdo_d    = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cs_level_s) begin
          // Level rather than rise: a rise hidden behind LOAD still ends the frame.
          state_d     = IDLE;
          busy_d      = 1'b0;
          sdo_oe_d    = 1'b0;
          sdo_d       = 1'b1;
          word_bnd_d  = 1'b0;
          frame_err_d = (bit_c_q != 3'd0);
          bit_c_d     = 3'd0;
        end else if (sample_s) begin
          rx_sh_d = rx_next_s;
          bit_c_d = bit_c_q + 3'd1;
          if (bit_c_q == 3'd7) begin
            rx_data_d  = rx_next_s;
            rx_valid_d = 1'b1;
            word_bnd_d = 1'b1;
          end else begin
            word_bnd_d = word_bnd_q;
          end
        end else if (shout_s) begin
          if (word_bnd_q) begin
            reload_s      = 1'b1;
            tx_underrun_d = ~shadow_full_q;
            word_bnd_d    = 1'b0;
            sdo_d         = head_bit(reload_word_s, mode_q.msb_lsb);
            tx_sh_d       = shift_out(reload_word_s, mode_q.msb_lsb);
          end else begin
            sdo_d   = head_bit(tx_sh_q, mode_q.msb_lsb);
            tx_sh_d = shift_out(tx_sh_q, mode_q.msb_lsb);
          end
        end else begin
          state_d = SHIFT;
        end
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        sdo_d    = 1'b1;
        sdo_oe_d = 1'b0;
      end
    endcase

    // A reload empties the shadow; a same-cycle client write refills it.
    if (reload_s) begin
      shadow_full_d = 1'b0;
    end else begin
      shadow_full_d = shadow_full_q;
    end
    if (wr_s) begin
      shadow_d      = tx_data;
      shadow_full_d = 1'b1;
    end else begin
      shadow_d = shadow_q;
    end

    // Disable behaves like reset: everything back to idle values, writes dropped.
    if (!tr_en) begin
      state_d       = IDLE;
      mode_d        = '0;
      tx_sh_d       = 8'hFF;
      rx_sh_d       = 8'h00;
      shadow_d      = 8'h00;
      shadow_full_d = 1'b0;
      rx_data_d     = 8'h00;
      bit_c_d       = 3'd0;
      word_bnd_d    = 1'b0;
      busy_d        = 1'b0;
      sdo_d         = 1'b1;
      sdo_oe_d      = 1'b0;
      rx_valid_d    = 1'b0;
      tx_underrun_d = 1'b0;
      frame_err_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      tx_sh_q       <= 8'hFF;
      rx_sh_q       <= 8'h00;
      shadow_q      <= 8'h00;
      shadow_full_q <= 1'b0;
      rx_data_q     <= 8'h00;
      bit_c_q       <= 3'd0;
      word_bnd_q    <= 1'b0;
      busy_q        <= 1'b0;
      sdo_q         <= 1'b1;
      sdo_oe_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      rx_data_q     <= rx_data_d;
      bit_c_q       <= bit_c_d;
      word_bnd_q    <= word_bnd_d;
      busy_q        <= busy_d;
      sdo_q         <= sdo_d;
      sdo_oe_q      <= sdo_oe_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign tx_ready    = ~shadow_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign sdo         = sdo_q;
  assign sdo_oe      = sdo_oe_q;

endmodule

// File: tb/tb_spi_slave_sv.sv
// Bench for spi_slave_sv: behavioural SPI master, table of single-word
// frames, hand-written multi-word / abort sequences and random loopback.
// Received words are checked through a scoreboard queue.
module tb_spi_slave_sv;

  localparam int H = 8;  // sck half period in clk cycles

  logic       clk = 1'b0;
  logic       reset, tr_en, cpol, cpha, msb_lsb;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_err, busy;
  logic       sck, cs, sdi, sdo, sdo_oe;

  int checks = 0;
  int errors = 0;
  int n_rxv  = 0;
  int n_urun = 0;
  int n_ferr = 0;

  logic [7:0] rx_q[$];
  logic [7:0] m_tx[4];
  logic [7:0] m_rx[4];

  typedef struct {
    logic       pol;
    logic       pha;
    logic       msb;
    logic       shd_en;
    logic [7:0] shd;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    int         exp_urun;
  } vec_t;

  vec_t vt[6];

  spi_slave_sv dut (
    .clk         (clk),
    .reset       (reset),
    .tr_en       (tr_en),
    .cpol        (cpol),
    .cpha        (cpha),
    .msb_lsb     (msb_lsb),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_err   (frame_err),
    .busy        (busy),
    .sck         (sck),
    .cs          (cs),
    .sdi         (sdi),
    .sdo         (sdo),
    .sdo_oe      (sdo_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard / pulse monitor, sampled on the falling clock edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        n_rxv++;
        checks++;
        if (rx_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got %02h expected no word", rx_data);
        end else begin
          e = rx_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
          end
        end
      end
      if (tx_underrun) n_urun++;
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_h();
    repeat (H) @(posedge clk);
    #2;
  endtask

  task automatic write_shadow(input logic [7:0] v);
    int t;
    t = 0;
    while (tx_ready !== 1'b1 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (tx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout: got %0b expected 1", tx_ready);
    end else begin
      tx_data  = v;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  // Behavioural master: nw words, last one nb_last bits; ends just after cs rises.
  task automatic frame(input logic pol, input logic pha, input logic msb, input int nw,
                       input int nb_last, input bit push, input bit refill,
                       input logic [7:0] refill_v);
    cpol = pol; cpha = pha; msb_lsb = msb; sck = pol;
    repeat (4) @(posedge clk);
    #2 cs = 1'b0;
    for (int w = 0; w < nw; w++) begin
      int nb;
      nb = (w == nw - 1) ? nb_last : 8;
      if (push && nb == 8) rx_q.push_back(m_tx[w]);
      m_rx[w] = 8'h00;
      for (int b = 0; b < nb; b++) begin
        int idx;
        idx = msb ? 7 - b : b;
        if (!pha) begin
          sdi = m_tx[w][idx];
          wait_h(); sck = ~pol; m_rx[w][idx] = sdo;
          wait_h(); sck = pol;
        end else begin
          wait_h(); sck = ~pol; sdi = m_tx[w][idx];
          wait_h(); sck = pol; m_rx[w][idx] = sdo;
        end
        if (refill && w == 0 && b == 2) write_shadow(refill_v);
      end
    end
    wait_h();
    cs = 1'b1;
  endtask

  task automatic idle();
    wait_h(); wait_h();
  endtask

  initial begin
    int u0, r0, f0;
    logic [7:0] s, m;
    logic       pol, pha, msb;

    vt[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
    vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h96, 8'hFF, 1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h0F, 8'hC3, 8'h0F, 1};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'hE7, 8'h12, 0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h01, 8'h80, 0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 8'h01, 1};

    reset = 1'b1; tr_en = 1'b1; cpol = 1'b0; cpha = 1'b0; msb_lsb = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; sck = 1'b0; cs = 1'b1; sdi = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sdo", sdo, 1);
    chk("rst_sdo_oe", sdo_oe, 0);

    // Single-word frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].shd_en) begin
        write_shadow(vt[i].shd);
        chk("tx_ready_full", tx_ready, 0);
      end
      m_tx[0] = vt[i].mosi;
      u0 = n_urun;
      frame(vt[i].pol, vt[i].pha, vt[i].msb, 1, 8, 1'b1, 1'b0, 8'h00);
      idle();
      chk($sformatf("vec%0d_miso", i), m_rx[0], vt[i].exp_miso);
      chk($sformatf("vec%0d_urun", i), n_urun - u0, vt[i].exp_urun);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_sdo_oe", i), sdo_oe, 0);
      chk($sformatf("vec%0d_tx_ready", i), tx_ready, 1);
    end

    // Mode 3, LSB-first, two words, shadow refilled during word 1.
    write_shadow(8'h5A);
    m_tx[0] = 8'hC4; m_tx[1] = 8'h2B;
    u0 = n_urun; r0 = n_rxv;
    frame(1'b1, 1'b1, 1'b0, 2, 8, 1'b1, 1'b1, 8'h81);
    idle();
    chk("two_w0_miso", m_rx[0], 8'h5A);
    chk("two_w1_miso", m_rx[1], 8'h81);
    chk("two_urun", n_urun - u0, 0);
    chk("two_rxv", n_rxv - r0, 2);

    // cs rises after 5 bits.
    write_shadow(8'h5A);
    m_tx[0] = 8'hF0;
    f0 = n_ferr; r0 = n_rxv;
    frame(1'b0, 1'b0, 1'b1, 1, 5, 1'b0, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_busy", busy, 0);
    chk("ferr_sdo_oe", sdo_oe, 0);
    chk("ferr_rx_data", rx_data, 8'h2B);
    chk("ferr_rxv", n_rxv - r0, 0);
    idle();

    // tr_en dropped mid-word.
    write_shadow(8'h55);
    m_tx[0] = 8'h77;
    fork
      frame(1'b0, 1'b0, 1'b1, 1, 8, 1'b0, 1'b0, 8'h00);
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("tren_busy_before", busy, 1);
        tr_en = 1'b0;
        @(posedge clk);
        #1;
        chk("tren_busy", busy, 0);
        chk("tren_sdo", sdo, 1);
        chk("tren_sdo_oe", sdo_oe, 0);
        chk("tren_tx_ready", tx_ready, 1);
        chk("tren_rx_data", rx_data, 0);
        tr_en = 1'b1;
      end
    join
    idle();

    // Clean frame after the disable.
    write_shadow(8'h3A);
    m_tx[0] = 8'h5C;
    frame(1'b0, 1'b1, 1'b1, 1, 8, 1'b1, 1'b0, 8'h00);
    idle();
    chk("clean1_miso", m_rx[0], 8'h3A);
    chk("clean1_rx_data", rx_data, 8'h5C);

    // reset pulsed mid-frame.
    write_shadow(8'h66);
    m_tx[0] = 8'h99;
    fork
      frame(1'b1, 1'b1, 1'b0, 1, 8, 1'b0, 1'b0, 8'h00);
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("rstmid_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sdo", sdo, 1);
        chk("rstmid_sdo_oe", sdo_oe, 0);
        chk("rstmid_tx_ready", tx_ready, 1);
        chk("rstmid_rx_data", rx_data, 0);
        reset = 1'b0;
      end
    join
    idle();

    // Clean frame after the reset.
    write_shadow(8'hE1);
    m_tx[0] = 8'h1E;
    frame(1'b1, 1'b0, 1'b0, 1, 8, 1'b1, 1'b0, 8'h00);
    idle();
    chk("clean2_miso", m_rx[0], 8'hE1);
    chk("clean2_rx_data", rx_data, 8'h1E);

    // Random loopback over all modes and bit orders.
    for (int i = 0; i < 8; i++) begin
      pol = i[0]; pha = i[1]; msb = i[2];
      s = 8'($urandom); m = 8'($urandom);
      write_shadow(s);
      m_tx[0] = m;
      u0 = n_urun;
      frame(pol, pha, msb, 1, 8, 1'b1, 1'b0, 8'h00);
      idle();
      chk($sformatf("loop%0d_miso", i), m_rx[0], s);
      chk($sformatf("loop%0d_rx_data", i), rx_data, m);
      chk($sformatf("loop%0d_urun", i), n_urun - u0, pha ? 0 : 1);
    end

    chk("sb_empty", rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
